// File: rtl/rw_request_scheduler.sv
// Read/write request scheduler: separate read and write FIFOs, reads issued first, writes drained
// in batches on watermark, write age or read-after-write hazard.
module rw_request_scheduler #(
  parameter int unsigned ADDR_W        = 30,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned HIGH_WM       = 6,
  parameter int unsigned LOW_WM        = 2,
  parameter int unsigned MAX_WRITE_AGE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_request_type,
  input  logic [ADDR_W-1:0] in_request_address,
  input  logic [DATA_W-1:0] in_request_data,
  output logic              out_busy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_type,
  output logic [ADDR_W-1:0] cmd_address,
  output logic [DATA_W-1:0] cmd_data,
  output logic              write_mode
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned AgeW = $clog2(MAX_WRITE_AGE + 1);

  typedef enum logic [0:0] {StRead, StDrain} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rd_head_q, rd_head_d, rd_tail_q, rd_tail_d;
  logic [PtrW-1:0]   wr_head_q, wr_head_d, wr_tail_q, wr_tail_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, wr_cnt_after;
  logic [AgeW-1:0]   age_q, age_d;
  logic              raw_q, raw_d;
  logic [ADDR_W-1:0] rd_addr_q [DEPTH];
  logic [ADDR_W-1:0] rd_addr_d [DEPTH];
  logic [ADDR_W-1:0] wr_addr_q [DEPTH];
  logic [ADDR_W-1:0] wr_addr_d [DEPTH];
  logic [DATA_W-1:0] wr_data_q [DEPTH];
  logic [DATA_W-1:0] wr_data_d [DEPTH];

  logic rd_empty, rd_full, wr_empty, wr_full;
  logic accept, push_rd, push_wr, pop_rd, pop_wr, stall;
  logic raw_hit, raw_set;

  assign rd_empty   = (rd_cnt_q == '0);
  assign wr_empty   = (wr_cnt_q == '0);
  assign rd_full    = (rd_cnt_q == CntW'(DEPTH));
  assign wr_full    = (wr_cnt_q == CntW'(DEPTH));
  assign out_busy   = rd_full || wr_full;
  assign accept     = in_valid && !out_busy;
  assign push_rd    = accept && !in_request_type;
  assign push_wr    = accept && in_request_type;
  assign write_mode = (state_q == StDrain);
  assign cmd_valid  = write_mode ? !wr_empty : !rd_empty;
  assign stall      = cmd_valid && !cmd_ready;
  assign pop_rd     = cmd_valid && cmd_ready && !write_mode;
  assign pop_wr     = cmd_valid && cmd_ready && write_mode;
  assign cmd_type   = cmd_valid && write_mode;
  assign cmd_data   = cmd_type ? wr_data_q[wr_head_q] : '0;

  always_comb begin
    cmd_address = '0;
    if (cmd_valid) cmd_address = write_mode ? wr_addr_q[wr_head_q] : rd_addr_q[rd_head_q];
  end

  // Hazard compare covers every live write entry, including one popping this cycle.
  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CntW'(i) < wr_cnt_q) && (wr_addr_q[wr_head_q + PtrW'(i)] == in_request_address)) begin
        raw_hit = 1'b1;
      end
    end
  end
  assign raw_set = push_rd && raw_hit;

  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_tail_d = rd_tail_q;
    wr_tail_d = wr_tail_q;
    rd_head_d = rd_head_q;
    wr_head_d = wr_head_q;
    if (push_rd) begin
      rd_addr_d[rd_tail_q] = in_request_address;
      rd_tail_d            = rd_tail_q + PtrW'(1);
    end
    if (push_wr) begin
      wr_addr_d[wr_tail_q] = in_request_address;
      wr_data_d[wr_tail_q] = in_request_data;
      wr_tail_d            = wr_tail_q + PtrW'(1);
    end
    if (pop_rd) rd_head_d = rd_head_q + PtrW'(1);
    if (pop_wr) wr_head_d = wr_head_q + PtrW'(1);
    rd_cnt_d = rd_cnt_q + CntW'(push_rd) - CntW'(pop_rd);
    wr_cnt_d = wr_cnt_q + CntW'(push_wr) - CntW'(pop_wr);
    raw_d    = (wr_cnt_d == '0) ? 1'b0 : (raw_q || raw_set);
  end

  // A drain may end on the handshake that brings the write backlog down to the low watermark.
  assign wr_cnt_after = wr_cnt_q - CntW'(pop_wr);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRead: begin
        if (!stall && ((wr_cnt_q >= CntW'(HIGH_WM)) || raw_q || raw_set ||
                       (age_q >= AgeW'(MAX_WRITE_AGE)) || (rd_empty && !wr_empty))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!stall && (wr_empty || ((wr_cnt_after <= CntW'(LOW_WM)) && !raw_q && !raw_set &&
                                    !rd_empty))) begin
          state_d = StRead;
        end
      end
      default: state_d = StRead;
    endcase
  end

  always_comb begin
    age_d = age_q;
    if (state_q == StRead) begin
      if (state_d == StDrain) begin
        age_d = '0;
      end else if (!wr_empty && (age_q < AgeW'(MAX_WRITE_AGE))) begin
        age_d = age_q + AgeW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRead;
      rd_head_q <= '0;
      rd_tail_q <= '0;
      wr_head_q <= '0;
      wr_tail_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      age_q     <= '0;
      raw_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_head_q <= rd_head_d;
      rd_tail_q <= rd_tail_d;
      wr_head_q <= wr_head_d;
      wr_tail_q <= wr_tail_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      age_q     <= age_d;
      raw_q     <= raw_d;
    end
  end

  // Queue storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr_d;
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_data_d;
  end

endmodule

// File: tb/tb_rw_request_scheduler.sv
// Bench for rw_request_scheduler: directed vector table, corner-case sequences and a randomized
// run checked against a queue-based ordering model.
module tb_rw_request_scheduler;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_request_type, cmd_ready;
  logic [29:0] in_request_address;
  logic [15:0] in_request_data;
  logic        out_busy, cmd_valid, cmd_type, write_mode;
  logic [29:0] cmd_address;
  logic [15:0] cmd_data;

  rw_request_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_request_type    (in_request_type),
    .in_request_address (in_request_address),
    .in_request_data    (in_request_data),
    .out_busy           (out_busy),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_type           (cmd_type),
    .cmd_address        (cmd_address),
    .cmd_data           (cmd_data),
    .write_mode         (write_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_first;
    logic        iv;
    logic        it;
    logic [29:0] ia;
    logic [15:0] id;
    logic        rdy;
    logic [49:0] exp;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    logic [15:0] data;
    int          seq;
  } req_t;

  vec_t        vecs[$];
  req_t        rdq[$];
  req_t        wrq[$];
  int          checks = 0;
  int          failures = 0;
  int          seq_n = 0;
  logic        stall_prev = 1'b0;
  logic [47:0] prev_cmd = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [49:0] act, input logic [49:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [49:0] outs();
    return {out_busy, cmd_valid, cmd_type, cmd_address, cmd_data, write_mode};
  endfunction

  function automatic logic [49:0] e(input logic b, input logic v, input logic t,
                                    input logic [29:0] a, input logic [15:0] d, input logic w);
    return {b, v, t, a, d, w};
  endfunction

  function automatic vec_t mk(input bit r, input logic iv, input logic it, input logic [29:0] ia,
                              input logic [15:0] id, input logic rdy, input logic [49:0] ex);
    vec_t v;
    v.rst_first = r; v.iv = iv; v.it = it; v.ia = ia; v.id = id; v.rdy = rdy; v.exp = ex;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic it, input logic [29:0] ia,
                       input logic [15:0] id, input logic rdy);
    in_valid = iv; in_request_type = it; in_request_address = ia; in_request_data = id;
    cmd_ready = rdy;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("reset%0d", i), outs(), '0);
    end
    rst = 1'b0;
    rdq.delete();
    wrq.delete();
    stall_prev = 1'b0;
  endtask

  // One cycle of scoreboarded traffic: compare against the model, then advance the clock.
  task automatic cycle(input logic iv, input logic it, input logic [29:0] ia,
                       input logic [15:0] id, input logic rdy);
    logic busy_m, older_hit;
    req_t r;
    drive(iv, it, ia, id, rdy);
    busy_m = (rdq.size() == DEPTH) || (wrq.size() == DEPTH);
    check("busy", 50'(out_busy), 50'(busy_m));
    if (stall_prev) check("hold", 50'({cmd_valid, cmd_type, cmd_address, cmd_data}), 50'(prev_cmd));
    if (cmd_valid) begin
      check("mode", 50'(cmd_type), 50'(write_mode));
      if (rdy && cmd_type) begin
        check("wr_avail", 50'(wrq.size() != 0), 50'(1));
        if (wrq.size() != 0) begin
          check("wr_cmd", 50'({cmd_address, cmd_data}), 50'({wrq[0].addr, wrq[0].data}));
          void'(wrq.pop_front());
        end
      end else if (rdy) begin
        check("rd_avail", 50'(rdq.size() != 0), 50'(1));
        if (rdq.size() != 0) begin
          check("rd_cmd", 50'({cmd_address, cmd_data}), 50'({rdq[0].addr, 16'h0}));
          older_hit = 1'b0;
          foreach (wrq[j]) if (wrq[j].seq < rdq[0].seq && wrq[j].addr == rdq[0].addr) older_hit = 1'b1;
          check("raw_order", 50'(older_hit), 50'(0));
          void'(rdq.pop_front());
        end
      end
    end
    stall_prev = cmd_valid && !rdy;
    prev_cmd   = {cmd_valid, cmd_type, cmd_address, cmd_data};
    if (iv && !busy_m) begin
      r.addr = ia; r.data = id; r.seq = seq_n++;
      if (it) wrq.push_back(r);
      else rdq.push_back(r);
    end
    step();
  endtask

  initial begin
    int  n;
    bit  found;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);

    // Read-only stream, including push and pop in the same cycle.
    vecs.push_back(mk(1, 1, 0, 'h10, 0, 1, e(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 'h11, 0, 1, e(0, 1, 0, 'h10, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 'h12, 0, 1, e(0, 1, 0, 'h11, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 'h13, 0, 1, e(0, 1, 0, 'h12, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 0, 'h13, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0)));
    // RAW hazard: the write to 0x20 must go out before the read of 0x20.
    vecs.push_back(mk(1, 1, 0, 'h30, 0, 0, e(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 1, 'h20, 'hBEEF, 0, e(0, 1, 0, 'h30, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 'h20, 0, 0, e(0, 1, 0, 'h30, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 0, 'h30, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 1, 'h20, 'hBEEF, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 0, 'h20, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0)));
    // Watermark drain with a read backlog; drain stops at two pending writes.
    vecs.push_back(mk(1, 1, 0, 'h40, 0, 0, e(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 'h41, 0, 0, e(0, 1, 0, 'h40, 0, 0)));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 1, 1, 30'('h100 + i), 16'('hA000 + i), 0, e(0, 1, 0, 'h40, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, e(0, 1, 0, 'h40, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 0, 'h40, 0, 0)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 1, 30'('h100 + i), 16'('hA000 + i), 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 0, 'h41, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 1, 'h104, 'hA004, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 1, 1, 'h105, 'hA005, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0)));

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset(3);
      drive(vecs[i].iv, vecs[i].it, vecs[i].ia, vecs[i].id, vecs[i].rdy);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      step();
    end

    // Full read queue: ninth read and a write are dropped while busy.
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 30'('h50 + i), '0, 1'b0);
      check("full_pre", 50'(out_busy), 50'(0));
      step();
    end
    check("full_busy", 50'(out_busy), 50'(1));
    drive(1'b1, 1'b0, 'h58, '0, 1'b0);
    step();
    check("full_busy2", 50'(out_busy), 50'(1));
    drive(1'b1, 1'b1, 'h59, 'h5959, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_rd%0d", i), 50'({cmd_valid, cmd_type, cmd_address}),
            50'({1'b1, 1'b0, 30'('h50 + i)}));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("full_dropped", 50'(cmd_valid), 50'(0));
      step();
    end

    // Reset in the middle of a stalled transfer discards everything queued.
    do_reset(3);
    drive(1'b1, 1'b0, 'h70, '0, 1'b0); step();
    drive(1'b1, 1'b0, 'h71, '0, 1'b0); step();
    drive(1'b1, 1'b1, 'h72, 'h7272, 1'b0); step();
    do_reset(1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("midrst_idle", outs(), '0);
      step();
    end

    // Age drain: a lone write behind a continuous read stream still goes out in bounded time.
    do_reset(3);
    drive(1'b1, 1'b0, 'h300, '0, 1'b0); step();
    drive(1'b1, 1'b0, 'h301, '0, 1'b0); step();
    drive(1'b1, 1'b1, 'h60, 'h1234, 1'b1); step();
    found = 0;
    n = 0;
    while (!found && n < 200) begin
      n++;
      drive(1'b1, 1'b0, 30'('h400 + n), '0, 1'b1);
      if (cmd_valid && cmd_type) begin
        found = 1;
        check("age_cmd", 50'({cmd_address, cmd_data}), 50'({30'h60, 16'h1234}));
        check($sformatf("age_latency_%0d", n), 50'(n <= 66), 50'(1));
      end
      step();
    end
    check("age_found", 50'(found), 50'(1));

    // Randomized traffic with alternating ready-heavy and ready-starved phases.
    do_reset(3);
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom % 3) != 0, 1'($urandom % 2), 30'($urandom_range(0, 7)), 16'($urandom),
            ((k / 200) % 2 == 1) ? (($urandom % 4) == 0) : (($urandom % 4) != 0));
    end
    n = 0;
    while ((rdq.size() != 0 || wrq.size() != 0) && n < 300) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    check("rand_drained", 50'(rdq.size() + wrq.size()), 50'(0));
    check("rand_idle", 50'(cmd_valid), 50'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
